// File: rtl/ifid_pkg.sv
// ifid_pkg: shared constants and fetch-entry layout for the IF->ID fetch queue
package ifid_pkg;
    localparam int XLEN_DEF = 32;
    localparam int SIDE_W_DEF = 1;
    localparam logic [31:0] BUBBLE_NOP = 32'h0000_0013;
    localparam int SIDE_PRED = 0;
    typedef struct packed {
        logic [XLEN_DEF-1:0]   instr;
        logic [XLEN_DEF-1:0]   pc;
        logic [SIDE_W_DEF-1:0] side;
    } fetch_entry_t;
endpackage

// File: rtl/id_fetch_queue_if.sv
// id_fetch_queue_if: fetch request, memory return and decode-side handshake bundle
interface id_fetch_queue_if
    import ifid_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int SIDE_W = SIDE_W_DEF,
    parameter int DEPTH  = 4
) ();
    logic                     f_valid;
    logic [XLEN-1:0]          f_pc;
    logic [SIDE_W-1:0]        f_side;
    logic                     f_ready;
    logic [XLEN-1:0]          imem_rdata;
    logic                     flush;
    logic                     d_valid;
    logic                     d_ready;
    logic [XLEN-1:0]          d_instr;
    logic [XLEN-1:0]          d_pc;
    logic [SIDE_W-1:0]        d_side;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output f_valid, f_pc, f_side, imem_rdata, flush, d_ready,
        input  f_ready, d_valid, d_instr, d_pc, d_side, occupancy
    );

    modport slave (
        input  f_valid, f_pc, f_side, imem_rdata, flush, d_ready,
        output f_ready, d_valid, d_instr, d_pc, d_side, occupancy
    );
endinterface

// File: rtl/if_tag_pipe.sv
// if_tag_pipe: delays each accepted request's {valid,pc,side} to line up with imem read data
module if_tag_pipe
    import ifid_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int SIDE_W = SIDE_W_DEF,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [SIDE_W-1:0] in_side,
    output logic [LAT-1:0]    tag_vld,
    output logic [XLEN-1:0]   out_pc,
    output logic [SIDE_W-1:0] out_side
);
    logic [LAT-1:0][XLEN-1:0]   pc_q;
    logic [LAT-1:0][SIDE_W-1:0] side_q;

    // Valid bits shift one stage per cycle; kill drops everything in flight but still admits the new request
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tag_vld <= '0;
        else        tag_vld <= LAT'({tag_vld, in_valid}) & (kill ? LAT'(1) : {LAT{1'b1}});

    // Payload follows the valid bits; it is only observed when the matching valid bit is set
    always_ff @(posedge clk) begin
        pc_q   <= (LAT*XLEN)'({pc_q, in_pc});
        side_q <= (LAT*SIDE_W)'({side_q, in_side});
    end

    assign out_pc   = pc_q[LAT-1];
    assign out_side = side_q[LAT-1];
endmodule

// File: rtl/id_fetch_queue.sv
// id_fetch_queue: DEPTH-entry IF->ID queue with credit-based fetch admission and flush
module id_fetch_queue
    import ifid_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              SIDE_W       = SIDE_W_DEF,
    parameter int              DEPTH        = 4,
    parameter int              MEM_LAT      = 1,
    parameter logic [XLEN-1:0] BUBBLE_INSTR = XLEN'(BUBBLE_NOP)
) (
    input logic              clk,
    input logic              rst_n,
    id_fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [XLEN-1:0]   pc;
        logic [SIDE_W-1:0] side;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              head;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [OW-1:0]       occ;
    logic [MEM_LAT-1:0]  tag_vld;
    logic [XLEN-1:0]     ret_pc;
    logic [SIDE_W-1:0]   ret_side;
    logic                has_head, accept, push, pop;

    if_tag_pipe #(.XLEN(XLEN), .SIDE_W(SIDE_W), .LAT(MEM_LAT)) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .kill     (bus.flush),
        .in_valid (accept),
        .in_pc    (bus.f_pc),
        .in_side  (bus.f_side),
        .tag_vld  (tag_vld),
        .out_pc   (ret_pc),
        .out_side (ret_side)
    );

    // Credit counts in-flight reads too, so a returning read always finds a free slot
    assign bus.f_ready = (int'(occ) + $countones(tag_vld)) < DEPTH;
    assign accept      = bus.f_valid & bus.f_ready;
    assign has_head    = occ != '0;
    assign push        = tag_vld[MEM_LAT-1] & ~bus.flush;
    assign pop         = has_head & bus.d_ready & ~bus.flush;

    // Pointer and occupancy bookkeeping; flush empties the queue and wins over push/pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            rd_ptr <= wr_ptr;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            occ    <= occ + OW'(push) - OW'(pop);
        end

    // Entry storage is only read behind a valid head, so it carries no reset
    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr] <= '{instr: bus.imem_rdata, pc: ret_pc, side: ret_side};

    assign head          = mem_q[rd_ptr];
    assign bus.d_valid   = has_head;
    assign bus.d_instr   = has_head ? head.instr : BUBBLE_INSTR;
    assign bus.d_pc      = has_head ? head.pc : '0;
    assign bus.d_side    = has_head ? head.side : '0;
    assign bus.occupancy = occ;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && occ == OW'(DEPTH)));
endmodule

// File: tb/tb_id_fetch_queue.sv
// tb_id_fetch_queue: drives MEM_LAT=1 and MEM_LAT=2 queues with shared stimulus against a timing scoreboard
module tb_id_fetch_queue;
    import ifid_pkg::*;

    localparam int XLEN  = 32;
    localparam int SW    = 1;
    localparam int DEPTH = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          f_valid = 0;
    logic [31:0]   f_pc = 0;
    logic [SW-1:0] f_side = 0;
    logic          d_ready = 0;
    logic          flush = 0;
    int            checks = 0;
    int            errors = 0;
    int            acc;

    typedef struct {
        fetch_entry_t e;
        int           rdy;
    } exp_t;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h0101};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = g + 1;
        id_fetch_queue_if #(.XLEN(XLEN), .SIDE_W(SW), .DEPTH(DEPTH)) bus ();
        logic [31:0] pc_d [LAT];
        exp_t        q [$];
        exp_t        x;
        int          cyc = 0;
        int          vis;
        logic        ev, fr;

        id_fetch_queue #(.XLEN(XLEN), .SIDE_W(SW), .DEPTH(DEPTH), .MEM_LAT(LAT)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.f_valid    = f_valid;
        assign bus.f_pc       = f_pc;
        assign bus.f_side     = f_side;
        assign bus.d_ready    = d_ready;
        assign bus.flush      = flush;
        assign bus.imem_rdata = mem_word(pc_d[LAT-1]);

        always @(posedge clk) begin
            pc_d[0] <= f_pc;
            for (int i = 1; i < LAT; i++) pc_d[i] <= pc_d[i-1];
        end

        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) q.delete();
            else begin
                vis = 0;
                foreach (q[i]) if (q[i].rdy <= cyc) vis++;
                ev = q.size() > 0 && q[0].rdy <= cyc;
                fr = q.size() < DEPTH;
                chk($sformatf("L%0d f_ready", LAT), bus.f_ready, fr);
                chk($sformatf("L%0d d_valid", LAT), bus.d_valid, ev);
                chk($sformatf("L%0d occupancy", LAT), bus.occupancy, vis);
                chk($sformatf("L%0d d_pc", LAT), bus.d_pc, ev ? q[0].e.pc : 32'h0);
                chk($sformatf("L%0d d_instr", LAT), bus.d_instr, ev ? q[0].e.instr : 32'h13);
                chk($sformatf("L%0d d_side", LAT), bus.d_side, ev ? q[0].e.side : 1'b0);
                if (flush) q.delete();
                else if (ev && d_ready) void'(q.pop_front());
                if (f_valid && fr) begin
                    x.e.instr = mem_word(f_pc);
                    x.e.pc    = f_pc;
                    x.e.side  = f_side;
                    x.rdy     = cyc + LAT + 1;
                    q.push_back(x);
                end
                cyc++;
            end
        end
    end

    task automatic tick(input logic v, input logic [31:0] pc, input logic s, input logic dr, input logic fl);
        @(posedge clk);
        #1;
        f_valid = v;
        f_pc = pc;
        f_side[SIDE_PRED] = s;
        d_ready = dr;
        flush = fl;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst d_valid", g_lane[0].bus.d_valid, 0);
        chk("rst occupancy", g_lane[0].bus.occupancy, 0);
        chk("rst f_ready", g_lane[0].bus.f_ready, 1);
        chk("rst d_instr", g_lane[0].bus.d_instr, 32'h13);
        chk("rst d_pc", g_lane[1].bus.d_pc, 0);
        rst_n = 1;

        tick(1, 32'h0, 0, 1, 0);
        tick(1, 32'h4, 0, 1, 0);
        tick(1, 32'h8, 0, 1, 0);
        chk("t1 L1 c2 d_valid", g_lane[0].bus.d_valid, 1);
        chk("t1 L1 c2 d_pc", g_lane[0].bus.d_pc, 32'h0);
        chk("t1 L1 c2 d_instr", g_lane[0].bus.d_instr, mem_word(32'h0));
        chk("t1 L2 c2 d_valid", g_lane[1].bus.d_valid, 0);
        chk("t1 L2 c2 bubble", g_lane[1].bus.d_instr, 32'h13);
        tick(0, 32'h0, 0, 1, 0);
        chk("t1 L1 c3 d_pc", g_lane[0].bus.d_pc, 32'h4);
        chk("t1 L2 c3 d_pc", g_lane[1].bus.d_pc, 32'h0);
        tick(0, 32'h0, 0, 1, 0);
        chk("t1 L1 c4 d_pc", g_lane[0].bus.d_pc, 32'h8);
        chk("t1 L1 c4 d_instr", g_lane[0].bus.d_instr, mem_word(32'h8));
        chk("t1 L2 c4 d_pc", g_lane[1].bus.d_pc, 32'h4);
        repeat (3) tick(0, 32'h0, 0, 1, 0);

        acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1, 32'h100 + 32'(4 * i), 0, 0, 0);
            if (g_lane[0].bus.f_ready) acc++;
            if (i == 4) chk("t2 f_ready after 4th", g_lane[0].bus.f_ready, 0);
        end
        chk("t2 accepts", acc, 4);
        chk("t2 L1 occupancy", g_lane[0].bus.occupancy, DEPTH);
        chk("t2 L2 occupancy", g_lane[1].bus.occupancy, DEPTH);
        for (int i = 0; i < 4; i++) begin
            tick(0, 32'h0, 0, 1, 0);
            chk("t2 L1 drain", g_lane[0].bus.d_pc, 32'h100 + 32'(4 * i));
            chk("t2 L2 drain", g_lane[1].bus.d_pc, 32'h100 + 32'(4 * i));
        end
        repeat (2) tick(0, 32'h0, 0, 1, 0);

        tick(1, 32'h10, 0, 1, 0);
        tick(1, 32'h14, 0, 1, 0);
        tick(1, 32'h80, 0, 1, 1);
        chk("t3 flush cycle d_valid", g_lane[1].bus.d_valid, 0);
        for (int k = 0; k < 2; k++) begin
            tick(0, 32'h0, 0, 1, 0);
            chk("t3 killed d_valid", g_lane[1].bus.d_valid, 0);
        end
        tick(0, 32'h0, 0, 1, 0);
        chk("t3 target d_valid", g_lane[1].bus.d_valid, 1);
        chk("t3 target d_pc", g_lane[1].bus.d_pc, 32'h80);
        repeat (3) tick(0, 32'h0, 0, 1, 0);

        for (int i = 0; i < 7; i++) begin
            if (i < 3) tick(1, 32'h1c + 32'(4 * i), i == 1, 1, 0);
            else tick(0, 32'h0, 0, 1, 0);
            if (g_lane[0].bus.d_valid) chk("t4 side", g_lane[0].bus.d_side, g_lane[0].bus.d_pc == 32'h20);
            else chk("t4 bubble pc", g_lane[0].bus.d_pc, 0);
        end

        for (int i = 0; i < 6; i++) tick(1, 32'h200 + 32'(4 * i), 0, 0, 0);
        tick(1, 32'h300, 0, 1, 0);
        tick(1, 32'h304, 0, 0, 0);
        chk("t5 pre-reset accept", g_lane[0].bus.f_ready, 1);
        @(posedge clk);
        #1;
        f_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("t5 L1 rst d_valid", g_lane[0].bus.d_valid, 0);
        chk("t5 L1 rst occupancy", g_lane[0].bus.occupancy, 0);
        chk("t5 L2 rst occupancy", g_lane[1].bus.occupancy, 0);
        chk("t5 rst f_ready", g_lane[1].bus.f_ready, 1);
        #1 rst_n = 1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 32'h0, 0, 0, 0);
            chk("t5 L1 stale return", g_lane[0].bus.occupancy, 0);
            chk("t5 L2 stale return", g_lane[1].bus.occupancy, 0);
        end

        for (int i = 0; i < 10000; i++) begin
            tick($urandom_range(0, 9) < 7, 32'($urandom_range(0, 4095)) << 2, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
            chk("t6 L1 occ bound", g_lane[0].bus.occupancy <= DEPTH, 1);
            chk("t6 L2 occ bound", g_lane[1].bus.occupancy <= DEPTH, 1);
        end
        repeat (8) tick(0, 32'h0, 0, 1, 0);
        chk("t6 L1 drained", g_lane[0].bus.d_valid, 0);
        chk("t6 L2 drained", g_lane[1].bus.d_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
